// File: rtl/seq_shifter.sv
// Multi-cycle barrel-free shifter: one bit per clock, result held until the
// downstream ALU slices accept it.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start with a shift op code
// S_SHIFT | shifting shreg one bit per edge while cnt counts down
// S_HOLD  | sh_result valid, waiting for out_ready
module seq_shifter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [4:0]  shamt,
    input  logic        out_ready,
    output logic        busy,
    output logic        out_valid,
    output logic [31:0] sh_result
);

    localparam logic [2:0] OP_SLL = 3'b011;
    localparam logic [2:0] OP_SRL = 3'b100;
    localparam logic [2:0] OP_SRA = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      state, state_d;
    logic [31:0] shreg, shreg_d;
    logic [4:0]  cnt, cnt_d;
    logic [2:0]  op_q, op_q_d;
    logic [31:0] result_d;
    logic        valid_d;
    logic        busy_d;
    logic        accept;
    logic [31:0] shreg_step;

    assign accept = start && ((op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (accept)     state_d = S_SHIFT;
            S_SHIFT: if (cnt == 5'd0) state_d = S_HOLD;
            S_HOLD:  if (out_ready)  state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    // SRA refills from the live sign bit each step, so the sign survives all 31 steps
    always_comb begin
        shreg_step = shreg;
        case (op_q)
            OP_SLL:  shreg_step = {shreg[30:0], 1'b0};
            OP_SRL:  shreg_step = {1'b0, shreg[31:1]};
            OP_SRA:  shreg_step = {shreg[31], shreg[31:1]};
            default: shreg_step = shreg;
        endcase
    end

    always_comb begin
        shreg_d  = shreg;
        cnt_d    = cnt;
        op_q_d   = op_q;
        result_d = sh_result;
        valid_d  = out_valid;
        busy_d   = (state_d != S_IDLE);
        case (state)
            S_IDLE: begin
                if (accept) begin
                    shreg_d = a;
                    cnt_d   = shamt;
                    op_q_d  = op;
                end
            end
            S_SHIFT: begin
                if (cnt != 5'd0) begin
                    shreg_d = shreg_step;
                    cnt_d   = cnt - 5'd1;
                end else begin
                    result_d = shreg;
                    valid_d  = 1'b1;
                end
            end
            S_HOLD: begin
                if (out_ready) valid_d = 1'b0;
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= 32'd0;
            cnt       <= 5'd0;
            op_q      <= 3'd0;
            sh_result <= 32'd0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            shreg     <= shreg_d;
            cnt       <= cnt_d;
            op_q      <= op_q_d;
            sh_result <= result_d;
            out_valid <= valid_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports SHALL be exactly those below, listed as name, direction, width, meaning.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request pulse, sampled only in IDLE.
REQ-005 op  input  3  ALU op code: 3'b011 = SLL, 3'b100 = SRL, 3'b101 = SRA; all others are non-shift.
REQ-006 a  input  32  operand to shift.
REQ-007 shamt  input  5  shift amount, 0..31.
REQ-008 out_ready  input  1  downstream ALU slices consume the result.
REQ-009 busy  output  1  high in SHIFT and HOLD.
REQ-010 out_valid  output  1  sh_result is final.
REQ-011 sh_result  output  32  registered shift result; bit i feeds sh_result of ALU slice i.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and HOLD, with internal registers shreg[31:0], cnt[4:0] and op_q[2:0].
REQ-013 In IDLE with start=1 and op in {011,100,101}, the block SHALL latch a->shreg, shamt->cnt, op->op_q and go to SHIFT on that edge.
REQ-014 In IDLE with start=1 and any other op, the request SHALL be ignored with no state or output change.
REQ-015 In SHIFT with cnt!=0, each edge SHALL shift shreg by exactly 1 bit per op_q and decrement cnt by 1.
REQ-016 SLL SHALL shift left with zero fill at bit 0.
REQ-017 SRL SHALL shift right with zero fill at bit 31.
REQ-018 SRA SHALL shift right, refilling bit 31 from the current shreg[31], so the sign is preserved across all steps.
REQ-019 In SHIFT with cnt==0, the next edge SHALL copy shreg->sh_result, set out_valid=1 and go to HOLD.
REQ-020 Latency SHALL be: start sampled at edge k gives out_valid=1 after edge k+shamt+1; shamt=0 therefore gives sh_result=a after 1 cycle.
REQ-021 In HOLD, out_valid and sh_result SHALL stay stable until out_ready=1 is sampled, after which the next edge SHALL clear out_valid and return to IDLE.
REQ-022 In HOLD, the out_valid/out_ready handshake SHALL take one cycle when out_ready is already high.
REQ-023 start SHALL be ignored whenever state != IDLE (SHIFT or HOLD), including when out_ready and start are high together in HOLD; no new request is accepted back-to-back in that cycle.
REQ-024 After a handshake, sh_result SHALL keep its last value while out_valid=0; consumers SHALL qualify sh_result with out_valid.
REQ-025 busy SHALL be a registered output derived from state only, and SHALL be 1 in SHIFT and HOLD and 0 in IDLE.
REQ-026 cnt SHALL never underflow, since decrement occurs only when cnt!=0.
REQ-027 No combinational path SHALL exist from any input to any output.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state=IDLE, shreg=0, cnt=0, op_q=0, sh_result=0, out_valid=0 and busy=0.
REQ-029 Reset asserted mid-SHIFT or mid-HOLD SHALL abort the operation with no partial result presented.
REQ-030 After rst_n deassertion, the first start SHALL be accepted on the first rising edge where rst_n=1.

Verification
REQ-031 op=011, a=32'h0000_0001, shamt=4, start pulse -> out_valid rises 5 cycles later, sh_result=32'h0000_0010, busy=1 throughout.
REQ-032 op=101, a=32'h8000_0000, shamt=31 -> after 32 cycles sh_result=32'hFFFF_FFFF; op=100 with the same inputs -> 32'h0000_0001.
REQ-033 op=100, a=32'hDEAD_BEEF, shamt=0 -> out_valid after 1 cycle, sh_result=32'hDEAD_BEEF.
REQ-034 Hold out_ready=0 for 3 cycles in HOLD and pulse start with new operands -> sh_result unchanged, start ignored; out_ready=1 -> IDLE next edge, out_valid=0.
REQ-035 start with op=3'b110 or 3'b000 in IDLE -> busy stays 0 and no output changes.
REQ-036 Drive rst_n=0 between edges at cycle 3 of shamt=20 -> outputs go to 0 immediately; after release a fresh op=011, a=1, shamt=1 -> sh_result=32'h2 after 2 cycles.
